regfile_writeback: RTL and testbench

// - Write-side driver of the 32x32 MIPS register file: owns the RegWrite/WriteRegister/WriteData port.
// - Merges single-cycle ALU results with multi-cycle results (load/mult/div), buffering the slow ones in a small FIFO.
// - Drops writes to $0; exposes pending-destination lookups so hazard logic can stall readers.

---
 rtl/regfile_wb_pkg.sv | 16 +
 rtl/wb_fifo.sv | 87 ++++++++
 rtl/regfile_writeback.sv | 115 +++++++++++
 tb/tb_regfile_writeback.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared widths, the zero-register constant and the slow-result FIFO entry layout
// for the register-file write-back block.
package regfile_wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    logic              kill;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending slow-unit results. A kill marks every buffered entry
// whose destination is overwritten by a younger ALU write. Also reports live rd matches.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_rd_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              kill_en_i,
  input  logic [ADDR_W-1:0] kill_rd_i,
  input  logic [ADDR_W-1:0] query_rs_i,
  input  logic [ADDR_W-1:0] query_rt_i,
  output wb_entry_t         head_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [DEPTH-1:0]  match_rs_o,
  output logic [DEPTH-1:0]  match_rt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // The pushed slot is never valid when written, so a same-cycle kill cannot hit it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en_i && valid_q[i] && (mem_q[i].rd == kill_rd_i)) mem_q[i].kill <= 1'b1;
      end
      if (pop_ok) valid_q[rd_ptr_q] <= 1'b0;
      if (push_ok) begin
        mem_q[wr_ptr_q]   <= '{rd: push_rd_i, data: push_data_i, kill: 1'b0};
        valid_q[wr_ptr_q] <= 1'b1;
      end
    end
  end

  always_comb begin
    match_rs_o = '0;
    match_rt_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_rs_o[i] = valid_q[i] && !mem_q[i].kill && (mem_q[i].rd == query_rs_i);
      match_rt_o[i] = valid_q[i] && !mem_q[i].kill && (mem_q[i].rd == query_rt_i);
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Write-side driver of the MIPS register file: ALU results win, slow results queue in wb_fifo.
// Define WB_BYPASS_EN to add read-port forwarding from the output stage (removes its stall term).
module regfile_writeback #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = regfile_wb_pkg::DATA_W,
  parameter int ADDR_W = regfile_wb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              slow_valid,
  output logic              slow_ready,
  input  logic [ADDR_W-1:0] slow_rd,
  input  logic [DATA_W-1:0] slow_data,
  input  logic [ADDR_W-1:0] query_rs,
  input  logic [ADDR_W-1:0] query_rt,
  output logic              pend_rs,
  output logic              pend_rt,
`ifdef WB_BYPASS_EN
  input  logic [DATA_W-1:0] rf_rs_data,
  input  logic [DATA_W-1:0] rf_rt_data,
  output logic [DATA_W-1:0] byp_rs_data,
  output logic [DATA_W-1:0] byp_rt_data,
`endif
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData
);

  import regfile_wb_pkg::*;

  wb_entry_t         head;
  logic              fifo_empty, fifo_full;
  logic              push, pop, head_write, alu_kill;
  logic [DEPTH-1:0]  match_rs, match_rt;
  logic              out_hit_rs, out_hit_rt;

  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  assign slow_ready = !fifo_full;
  assign push       = slow_valid && slow_ready;
  // Killed heads drain even under ALU traffic; live heads wait for an ALU gap.
  assign pop        = !fifo_empty && (head.kill || !alu_valid);
  assign head_write = pop && !head.kill && (head.rd != REG_ZERO);
  assign alu_kill   = alu_valid && (alu_rd != REG_ZERO);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_rd_i  (slow_rd),
    .push_data_i(slow_data),
    .pop_i      (pop),
    .kill_en_i  (alu_kill),
    .kill_rd_i  (alu_rd),
    .query_rs_i (query_rs),
    .query_rt_i (query_rt),
    .head_o     (head),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full),
    .match_rs_o (match_rs),
    .match_rt_o (match_rt)
  );

  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (alu_valid) begin
      if (alu_rd != REG_ZERO) begin
        reg_write_d  = 1'b1;
        write_reg_d  = alu_rd;
        write_data_d = alu_data;
      end
    end else if (head_write) begin
      reg_write_d  = 1'b1;
      write_reg_d  = head.rd;
      write_data_d = head.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign RegWrite      = reg_write_q;
  assign WriteRegister = write_reg_q;
  assign WriteData     = write_data_q;

  assign out_hit_rs = reg_write_q && (write_reg_q == query_rs);
  assign out_hit_rt = reg_write_q && (write_reg_q == query_rt);

`ifdef WB_BYPASS_EN
  assign pend_rs     = (query_rs != REG_ZERO) && (|match_rs);
  assign pend_rt     = (query_rt != REG_ZERO) && (|match_rt);
  assign byp_rs_data = (out_hit_rs && (query_rs != REG_ZERO)) ? write_data_q : rf_rs_data;
  assign byp_rt_data = (out_hit_rt && (query_rt != REG_ZERO)) ? write_data_q : rf_rt_data;
`else
  assign pend_rs = (query_rs != REG_ZERO) && ((|match_rs) || out_hit_rs);
  assign pend_rt = (query_rt != REG_ZERO) && ((|match_rt) || out_hit_rt);
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback (default build): a vector table with
// hand-computed outputs, then full/wrap and mid-operation reset sequences.
module tb_regfile_writeback;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        slow_valid;
  logic        slow_ready;
  logic [4:0]  slow_rd;
  logic [31:0] slow_data;
  logic [4:0]  query_rs;
  logic [4:0]  query_rt;
  logic        pend_rs;
  logic        pend_rt;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;

  int passed = 0;
  int total  = 0;

  regfile_writeback #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .slow_valid   (slow_valid),
    .slow_ready   (slow_ready),
    .slow_rd      (slow_rd),
    .slow_data    (slow_data),
    .query_rs     (query_rs),
    .query_rt     (query_rt),
    .pend_rs      (pend_rs),
    .pend_rt      (pend_rt),
    .RegWrite     (RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs describe the cycle in which the inputs are applied:
  // registered outputs reflect the previous cycle, pend/ready the current one.
  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        sv;
    logic [4:0]  srd;
    logic [31:0] sdata;
    logic [4:0]  qrs;
    logic [4:0]  qrt;
    logic        eRw;
    logic [4:0]  eWr;
    logic [31:0] eWd;
    logic        eRdy;
    logic        ePrs;
    logic        ePrt;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                       input logic sv, input logic [4:0] srd, input logic [31:0] sdata,
                       input logic [4:0] qrs, input logic [4:0] qrt);
    alu_valid  = av;
    alu_rd     = ard;
    alu_data   = adata;
    slow_valid = sv;
    slow_rd    = srd;
    slow_data  = sdata;
    query_rs   = qrs;
    query_rt   = qrt;
  endtask

  task automatic applyStimulus(input vec_t v);
    drive(v.av, v.ard, v.adata, v.sv, v.srd, v.sdata, v.qrs, v.qrt);
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    check($sformatf("v%0d RegWrite", idx), 32'(RegWrite), 32'(v.eRw));
    if (v.eRw) begin
      check($sformatf("v%0d WriteRegister", idx), 32'(WriteRegister), 32'(v.eWr));
      check($sformatf("v%0d WriteData", idx), WriteData, v.eWd);
    end
    check($sformatf("v%0d slow_ready", idx), 32'(slow_ready), 32'(v.eRdy));
    check($sformatf("v%0d pend_rs", idx), 32'(pend_rs), 32'(v.ePrs));
    check($sformatf("v%0d pend_rt", idx), 32'(pend_rt), 32'(v.ePrt));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4:0]  obsRd [$];
    logic [31:0] obsData [$];
    int          nextRd;
    int          notReady;
    logic        accepted;

    //            av ard    adata         sv srd   sdata        qrs    qrt  | eRw eWr   eWd          rdy  prs  prt
    vecs[0]  = '{1'b1, 5'd8,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,   5'd8,  5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   5'd8,  5'd8,  1'b1, 5'd8,  32'hDEADBEEF, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 5'd20, 32'hA0,       1'b1, 5'd1,  32'h101, 5'd1,  5'd20, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 5'd21, 32'hA1,       1'b1, 5'd2,  32'h102, 5'd1,  5'd20, 1'b1, 5'd20, 32'hA0,       1'b1, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 5'd22, 32'hA2,       1'b1, 5'd3,  32'h103, 5'd2,  5'd3,  1'b1, 5'd21, 32'hA1,       1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 5'd23, 32'hA3,       1'b1, 5'd4,  32'h104, 5'd4,  5'd22, 1'b1, 5'd22, 32'hA2,       1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h999, 5'd4,  5'd9,  1'b1, 5'd23, 32'hA3,       1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   5'd1,  5'd2,  1'b1, 5'd1,  32'h101,      1'b1, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   5'd3,  5'd0,  1'b1, 5'd2,  32'h102,      1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   5'd9,  5'd4,  1'b1, 5'd3,  32'h103,      1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   5'd4,  5'd0,  1'b1, 5'd4,  32'h104,      1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'h11,  5'd5,  5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 5'd5,  32'h22,       1'b0, 5'd0,  32'h0,   5'd5,  5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   5'd5,  5'd0,  1'b1, 5'd5,  32'h22,       1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   5'd5,  5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  32'h61,  5'd6,  5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 5'd6,  32'h62,       1'b1, 5'd7,  32'h71,  5'd6,  5'd7,  1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 5'd7,  32'h72,       1'b0, 5'd0,  32'h0,   5'd7,  5'd6,  1'b1, 5'd6,  32'h62,       1'b1, 1'b1, 1'b1};
    vecs[18] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   5'd7,  5'd6,  1'b1, 5'd7,  32'h72,       1'b1, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   5'd7,  5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 5'd10, 32'hB0,       1'b1, 5'd10, 32'hB1,  5'd10, 5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   5'd10, 5'd0,  1'b1, 5'd10, 32'hB0,       1'b1, 1'b1, 1'b0};
    vecs[22] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   5'd10, 5'd0,  1'b1, 5'd10, 32'hB1,       1'b1, 1'b1, 1'b0};
    vecs[23] = '{1'b1, 5'd0,  32'hCC,       1'b1, 5'd0,  32'hDD,  5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0};
    vecs[24] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0};
    vecs[25] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,   5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0};

    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1 rst_n = 1'b0;
    #6;
    check("reset RegWrite", 32'(RegWrite), 32'd0);
    check("reset WriteRegister", 32'(WriteRegister), 32'd0);
    check("reset WriteData", WriteData, 32'd0);
    check("reset slow_ready", 32'(slow_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #2;
      checkOutput(vecs[i], i);
    end

    $display("[TB] full FIFO and pointer wrap");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 5'd0, 32'h0, 1'b1, 5'(11 + i), 32'h1100 + 32'(11 + i), 5'd0, 5'd0);
      #2;
      check($sformatf("fill%0d slow_ready", i), 32'(slow_ready), 32'd1);
    end
    @(negedge clk);
    drive(1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd11, 5'd14);
    #2;
    check("full slow_ready", 32'(slow_ready), 32'd0);
    check("full RegWrite", 32'(RegWrite), 32'd0);
    check("full pend_rs", 32'(pend_rs), 32'd1);
    check("full pend_rt", 32'(pend_rt), 32'd1);

    nextRd   = 15;
    notReady = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, (nextRd <= 17), 5'(nextRd), 32'h1100 + 32'(nextRd), 5'd0, 5'd0);
      #2;
      accepted = slow_valid && slow_ready;
      if (!slow_ready) notReady++;
      if (RegWrite) begin
        obsRd.push_back(WriteRegister);
        obsData.push_back(WriteData);
      end
      @(posedge clk);
      if (accepted) nextRd++;
    end
    check("wrap write count", 32'(obsRd.size()), 32'd7);
    check("wrap not-ready cycles", 32'(notReady), 32'd1);
    for (int k = 0; k < obsRd.size() && k < 7; k++) begin
      check($sformatf("wrap write%0d rd", k), 32'(obsRd[k]), 32'(11 + k));
      check($sformatf("wrap write%0d data", k), obsData[k], 32'h1100 + 32'(11 + k));
    end

    $display("[TB] reset with buffered results");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 5'd27, 32'h270 + 32'(i), 1'b1, 5'(24 + i), 32'h2400 + 32'(i), 5'd0, 5'd0);
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd24, 5'd27);
    #1;
    check("pre-reset RegWrite", 32'(RegWrite), 32'd1);
    check("pre-reset WriteData", WriteData, 32'h272);
    #1 rst_n = 1'b0;
    #1;
    check("async reset RegWrite", 32'(RegWrite), 32'd0);
    check("async reset WriteRegister", 32'(WriteRegister), 32'd0);
    check("async reset WriteData", WriteData, 32'd0);
    check("async reset slow_ready", 32'(slow_ready), 32'd1);
    check("async reset pend_rs", 32'(pend_rs), 32'd0);
    check("async reset pend_rt", 32'(pend_rt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    query_rt = 5'd25;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #2;
      check($sformatf("post-reset%0d RegWrite", c), 32'(RegWrite), 32'd0);
      check($sformatf("post-reset%0d pend_rs", c), 32'(pend_rs), 32'd0);
      check($sformatf("post-reset%0d pend_rt", c), 32'(pend_rt), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
